imem_loader: RTL and testbench

Boot-time instruction-memory writer for the 32-bit processor. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It writes the words to consecutive addresses 0..2^ADDR_W-1 of the instruction memory, the same space the fetch address counter walks. It holds the processor core in reset (`cpu_rst`) until the whole image is written, then releases it so fetch starts at address 0.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 93 +++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Handshake: a byte moves on a clock edge where in_valid && in_ready are both high.
// in_ready depends only on loader state, never on in_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes a full
// instruction image, holding the core in reset until the last word is committed.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       cpu_rst,
  output logic [1:0] state_dbg,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       asm_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              cpu_rst_q;

  logic              accept;
  logic              last_word;
  logic [ADDR_W-1:0] addr_d;

  assign accept    = (state_q == S_LOAD) && bus.in_valid;
  assign last_word = (addr_q == {ADDR_W{1'b1}});
  assign addr_d    = addr_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      addr_q     <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      wr_en_q   <= 1'b0;
      // Core leaves reset only on the cycle after DONE is first visible.
      cpu_rst_q <= !((state_q == S_DONE) && !start);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_LOAD;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= bus.in_data;
              2'd1: asm_q[15:8]  <= bus.in_data;
              2'd2: asm_q[23:16] <= bus.in_data;
              default: begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= {bus.in_data, asm_q};
                addr_q    <= addr_d;
                if (last_word) state_q <= S_DONE;
              end
            endcase
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state_q == S_LOAD);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q == S_LOAD);
  assign done         = (state_q == S_DONE);
  assign cpu_rst      = cpu_rst_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-exact vector table for the first words,
// then full-image sequences with a write scoreboard.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int WORD_W = 32;
  localparam int W      = ADDR_W + WORD_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, cpu_rst;
  logic [1:0] state_dbg;

  imem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cpu_rst   (cpu_rst),
    .state_dbg (state_dbg),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.wr_en) begin
      check("wr_gap", 64'(prev_we), 64'd0);
      check("wr_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("wr_word", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_q.pop_front()));
    end
    prev_we = bus.wr_en;
  end

  function automatic logic [31:0] word_of(input int base, input int step, input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'((base + step * (4 * w + k)) & 255);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit st);
    bit acc = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        tick();
        check("ready_in_gap", 64'(bus.in_ready), 64'd1);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    start = st;
    for (int c = 0; c < 16; c++) begin
      acc = bus.in_ready;
      tick();
      start = 1'b0;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Full 256-byte image; mid_start >= 0 pulses start together with that byte.
  task automatic load_image(input int base, input int step, input bit gaps, input int mid_start);
    for (int w = 0; w < 64; w++) exp_q.push_back({ADDR_W'(w), word_of(base, step, w)});
    for (int i = 0; i < 256; i++) send_byte(8'((base + step * i) & 255), gaps, (i == mid_start));
    bus.in_valid = 1'b0;
    check("final_done_busy_we_crst", 64'({done, busy, bus.wr_en, cpu_rst}), 64'b1011);
    tick();
    check("cpu_rst_release", 64'({done, cpu_rst, bus.wr_en}), 64'b100);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic [42:0] exp;   // {in_ready, wr_en, busy, done, cpu_rst, wr_addr, wr_data}
  } vec_t;

  vec_t vecs[13];

  function automatic logic [42:0] o(input logic rdy, input logic we, input logic bsy,
                                    input logic dn, input logic crst,
                                    input logic [5:0] a, input logic [31:0] d);
    return {rdy, we, bsy, dn, crst, a, d};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h55, o(0, 0, 0, 0, 1, 6'd0, 32'h0)};
    vecs[1]  = '{1'b0, 1'b1, 8'h55, o(0, 0, 0, 0, 1, 6'd0, 32'h0)};
    vecs[2]  = '{1'b1, 1'b1, 8'h55, o(1, 0, 1, 0, 1, 6'd0, 32'h0)};
    vecs[3]  = '{1'b0, 1'b1, 8'h10, o(1, 0, 1, 0, 1, 6'd0, 32'h0)};
    vecs[4]  = '{1'b0, 1'b0, 8'h99, o(1, 0, 1, 0, 1, 6'd0, 32'h0)};
    vecs[5]  = '{1'b0, 1'b1, 8'h11, o(1, 0, 1, 0, 1, 6'd0, 32'h0)};
    vecs[6]  = '{1'b0, 1'b1, 8'h12, o(1, 0, 1, 0, 1, 6'd0, 32'h0)};
    vecs[7]  = '{1'b0, 1'b1, 8'h13, o(1, 1, 1, 0, 1, 6'd0, 32'h13121110)};
    vecs[8]  = '{1'b0, 1'b1, 8'h20, o(1, 0, 1, 0, 1, 6'd0, 32'h13121110)};
    vecs[9]  = '{1'b0, 1'b1, 8'h21, o(1, 0, 1, 0, 1, 6'd0, 32'h13121110)};
    vecs[10] = '{1'b0, 1'b1, 8'h22, o(1, 0, 1, 0, 1, 6'd0, 32'h13121110)};
    vecs[11] = '{1'b0, 1'b1, 8'h23, o(1, 1, 1, 0, 1, 6'd1, 32'h23222120)};
    vecs[12] = '{1'b0, 1'b0, 8'h00, o(1, 0, 1, 0, 1, 6'd1, 32'h23222120)};

    // ---- reset values ----
    do_reset();
    check("reset_outputs", 64'({bus.in_ready, bus.wr_en, busy, done, cpu_rst, bus.wr_addr, bus.wr_data}),
          64'(o(0, 0, 0, 0, 1, 6'd0, 32'h0)));
    check("reset_state", 64'(state_dbg), 64'd0);

    // ---- cycle-exact table ----
    exp_q.push_back({6'd0, 32'h13121110});
    exp_q.push_back({6'd1, 32'h23222120});
    for (int r = 0; r < 13; r++) begin
      start        = vecs[r].st;
      bus.in_valid = vecs[r].vld;
      bus.in_data  = vecs[r].dat;
      tick();
      check($sformatf("vec%0d", r),
            64'({bus.in_ready, bus.wr_en, busy, done, cpu_rst, bus.wr_addr, bus.wr_data}),
            64'(vecs[r].exp));
    end
    start = 1'b0;
    check("table_sb_drained", 64'(exp_q.size()), 64'd0);

    // ---- IDLE ignores bytes, then start; start mid-load after word 10 ----
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_ready", 64'({bus.in_ready, bus.wr_en}), 64'b00);
    end
    pulse_start();
    load_image(0, 1, 1'b0, 44);

    // ---- start in DONE: reload with random valid gaps ----
    pulse_start();
    check("restart_flags", 64'({cpu_rst, busy, done}), 64'b110);
    load_image(0, 1, 1'b1, -1);

    // ---- start in DONE again: all-0xEE image ----
    pulse_start();
    check("restart2_flags", 64'({cpu_rst, busy, done}), 64'b110);
    load_image(8'hEE, 0, 1'b0, -1);

    // ---- reset mid-load after 6 bytes ----
    pulse_start();
    exp_q.push_back({6'd0, 32'h03020100});
    for (int i = 0; i < 6; i++) send_byte(8'(i), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", 64'({bus.in_ready, bus.wr_en, busy, done, cpu_rst}), 64'b00001);
    check("mid_rst_state", 64'(state_dbg), 64'd0);

    // ---- reset on the same edge as a fourth byte: write suppressed ----
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h43;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_suppress_we", 64'({bus.wr_en, cpu_rst}), 64'b01);
    tick();
    check("rst_sb_drained", 64'(exp_q.size()), 64'd0);

    // ---- fresh load 0xA0+i after reset ----
    pulse_start();
    load_image(8'hA0, 1, 1'b0, -1);
    check("a0_word0", 64'(word_of(8'hA0, 1, 0)), 64'h0000_0000_A3A2A1A0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
